fetch_prefetch_queue: RTL

Instruction-fetch front end feeding the fetch→decode register of the 5-stage RV32I data pipeline. Owns the PC, issues word fetches to a request/grant instruction-memory port with in-order, variable-latency responses, and buffers returned instructions in a small FIFO so decode sees a steady stream. Honours branch/jump redirects from execute and decode-stall hold. Outputs a NOP bubble whenever no instruction is ready.

---
 rtl/fetch_prefetch_queue.sv | 116 +++++++++++
 1 files changed

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues request/grant word fetches and
// buffers in-order responses for decode. Optional same-cycle bypass under FETCH_BYPASS_EN.
module fetch_prefetch_queue #(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_f_en_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_p_4
);

  localparam int          AW      = $clog2(DEPTH);
  localparam int          CW      = AW + 1;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUTSTANDING);

  logic [31:0]   fpc;
  logic [31:0]   pc_mem  [DEPTH];
  logic [31:0]   ins_mem [DEPTH];
  logic [31:0]   tag_mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, tag_rd, tag_wr;
  logic [CW-1:0] cnt, out_cnt, dsc_cnt;
  logic [CW:0]   credit;

  logic grant, rsp, keep, byp, push, take, pop_fifo;
  logic        vld_p0;
  logic [31:0] pc_p0, ins_p0;

  // Credit counts buffered entries plus live (non-discarded) responses still in flight,
  // so every response that will be kept already owns a FIFO slot.
  assign credit      = {1'b0, cnt} + {1'b0, out_cnt} - {1'b0, dsc_cnt};
  assign o_imem_req  = !i_rst && !i_redirect && (out_cnt < MAX_C) && (credit < {1'b0, DEPTH_C});
  assign o_imem_addr = fpc;

  assign grant = o_imem_req && i_imem_gnt;
  assign rsp   = i_imem_rvalid && (out_cnt != '0);
  assign keep  = rsp && !i_redirect && (dsc_cnt == '0);

`ifdef FETCH_BYPASS_EN
  assign byp = keep && (cnt == '0);
`else
  assign byp = 1'b0;
`endif

  // Head stage: FIFO head, or the arriving response when bypassing an empty queue
  always_comb begin
    vld_p0 = (cnt != '0) || byp;
    pc_p0  = (cnt != '0) ? pc_mem[rd_ptr]  : tag_mem[tag_rd];
    ins_p0 = (cnt != '0) ? ins_mem[rd_ptr] : i_imem_rdata;
  end

  assign take     = vld_p0 && i_f_en_pc && !i_redirect;
  assign pop_fifo = take && (cnt != '0);
  assign push     = keep && !(byp && i_f_en_pc);

  assign o_valid  = vld_p0;
  assign o_instr  = vld_p0 ? ins_p0 : NOP;
  assign o_pc     = vld_p0 ? pc_p0 : 32'h0;
  assign o_pc_p_4 = vld_p0 ? (pc_p0 + 32'd4) : 32'h0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fpc     <= RESET_PC;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      tag_rd  <= '0;
      tag_wr  <= '0;
      cnt     <= '0;
      out_cnt <= '0;
      dsc_cnt <= '0;
    end else begin
      if (grant) tag_wr <= tag_wr + 1'b1;
      if (rsp)   tag_rd <= tag_rd + 1'b1;
      out_cnt <= out_cnt + CW'(grant) - CW'(rsp);
      if (i_redirect) begin
        fpc     <= {i_redirect_pc[31:2], 2'b00};
        dsc_cnt <= out_cnt - CW'(rsp);
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        cnt     <= '0;
      end else begin
        if (grant) fpc <= fpc + 32'd4;
        if (rsp && (dsc_cnt != '0)) dsc_cnt <= dsc_cnt - 1'b1;
        if (push)     wr_ptr <= wr_ptr + 1'b1;
        if (pop_fifo) rd_ptr <= rd_ptr + 1'b1;
        cnt <= cnt + CW'(push) - CW'(pop_fifo);
      end
    end
  end

  // Storage stage: tag queue of granted addresses and the {pc, instr} FIFO
  always_ff @(posedge i_clk) begin
    if (grant) tag_mem[tag_wr] <= fpc;
    if (push) begin
      pc_mem[wr_ptr]  <= tag_mem[tag_rd];
      ins_mem[wr_ptr] <= i_imem_rdata;
    end
  end

  a_no_orphan_rvalid: assert property (@(posedge i_clk) disable iff (i_rst)
    i_imem_rvalid |-> (out_cnt != '0));

endmodule
